// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: digit count,
// blank pattern, hex-to-segment table and the display buffer word.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} with dp off; entry 0 is the rightmost byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [31:0]           value;
    logic [NUM_DIGITS-1:0] en;
    logic [NUM_DIGITS-1:0] dp;
  } display_word_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern, with the
// decimal point carried in bit 7.
import display_pkg::*;

module hex_to_7seg (
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] segment_o
);

  logic [7:0] pattern;

  assign pattern   = SEG_TABLE[nibble_i];
  assign segment_o = {~dp_i, pattern[6:0]};

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans an 8-digit multiplexed display with a per-slot blank interval;
// updates are double-buffered and only take effect at a frame boundary.
import display_pkg::*;

module seven_seg_scanner #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        update_valid,
  output logic        update_ready,
  input  logic [31:0] value_in,
  input  logic [7:0]  digit_en_in,
  input  logic [7:0]  dp_in,
  output logic        frame_start,
  output logic [7:0]  segment,
  output logic [7:0]  anode
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  display_word_t  pend_q, pend_d;
  display_word_t  act_q, act_d;
  logic           pend_full_q, pend_full_d;
  logic           rdy_q;
  logic [7:0]     seg_q, seg_d;
  logic [7:0]     anode_q, anode_d;
  logic           fs_q, fs_d;

  logic           slot_wrap;
  logic           frame_end;
  logic           xfer;
  logic           lit;
  logic [3:0]     cur_nibble;
  logic [7:0]     cur_seg;

  assign cur_nibble = act_q.value[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble_i  (cur_nibble),
    .dp_i      (act_q.dp[idx_q]),
    .segment_o (cur_seg)
  );

  always_comb begin
    slot_wrap   = (cnt_q == CNT_LAST);
    frame_end   = slot_wrap && (idx_q == 3'd7);
    xfer        = update_valid && rdy_q;

    cnt_d       = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d       = slot_wrap ? idx_q + 3'd1 : idx_q;

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;

    // xfer implies the pending buffer is empty, so promotion and capture never collide.
    if (frame_end && pend_full_q) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_d      = '{value: value_in, en: digit_en_in, dp: dp_in};
      pend_full_d = 1'b1;
    end

    lit     = (cnt_q >= CNT_BLANK) && act_q.en[idx_q];
    anode_d = lit ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d   = lit ? cur_seg : SEG_BLANK;
    fs_d    = (cnt_q == '0) && (idx_q == 3'd0);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
      rdy_q       <= 1'b1;
      seg_q       <= SEG_BLANK;
      anode_q     <= 8'hFF;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
      rdy_q       <= ~pend_full_d;
      seg_q       <= seg_d;
      anode_q     <= anode_d;
      fs_q        <= fs_d;
    end
  end

  assign update_ready = rdy_q;
  assign segment      = seg_q;
  assign anode        = anode_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a per-cycle expected-output
// scoreboard plus spot checks of specific digits.
module tb_seven_seg_scanner;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * DC;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        update_valid = 1'b0;
  logic [31:0] value_in = '0;
  logic [7:0]  digit_en_in = '0;
  logic [7:0]  dp_in = '0;
  logic        update_ready;
  logic        frame_start;
  logic [7:0]  segment;
  logic [7:0]  anode;

  seven_seg_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .update_valid (update_valid),
    .update_ready (update_ready),
    .value_in     (value_in),
    .digit_en_in  (digit_en_in),
    .dp_in        (dp_in),
    .frame_start  (frame_start),
    .segment      (segment),
    .anode        (anode)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] sb_q[$];
  int          mp;
  logic        m_full;
  logic [47:0] m_pend;
  logic [47:0] m_act;

  function automatic logic [7:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: ref_seg = 8'hC0;  4'h1: ref_seg = 8'hF9;
      4'h2: ref_seg = 8'hA4;  4'h3: ref_seg = 8'hB0;
      4'h4: ref_seg = 8'h99;  4'h5: ref_seg = 8'h92;
      4'h6: ref_seg = 8'h82;  4'h7: ref_seg = 8'hF8;
      4'h8: ref_seg = 8'h80;  4'h9: ref_seg = 8'h90;
      4'hA: ref_seg = 8'h88;  4'hB: ref_seg = 8'h83;
      4'hC: ref_seg = 8'hC6;  4'hD: ref_seg = 8'hA1;
      4'hE: ref_seg = 8'h86;  default: ref_seg = 8'h8E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model, push expected outputs, then compare at negedge.
  task automatic step(output logic acc);
    logic [7:0]  ea;
    logic [7:0]  es;
    logic        efs;
    int          di;
    int          dcnt;
    logic [24:0] exp;
    logic [24:0] got;
    acc = 1'b0;
    if (ARESET) begin
      ea = 8'hFF; es = 8'hFF; efs = 1'b0;
      mp = 0; m_full = 1'b0; m_pend = '0; m_act = '0;
    end else begin
      di   = mp / DC;
      dcnt = mp % DC;
      efs  = (mp == 0);
      if (dcnt < BC || !m_act[8 + di]) begin
        ea = 8'hFF; es = 8'hFF;
      end else begin
        ea = ~(8'h01 << di);
        es = ref_seg(m_act[16 + 4 * di +: 4]);
        es[7] = ~m_act[di];
      end
      acc = update_valid && !m_full;
      if (mp == FRAME - 1 && m_full) begin
        m_act  = m_pend;
        m_full = 1'b0;
      end
      if (acc) begin
        m_pend = {value_in, digit_en_in, dp_in};
        m_full = 1'b1;
      end
      mp = (mp + 1) % FRAME;
    end
    sb_q.push_back({ea, es, efs, ~m_full});
    @(posedge ACLK);
    @(negedge ACLK);
    exp = sb_q.pop_front();
    got = {anode, segment, frame_start, update_ready};
    check("cycle{anode,seg,fs,rdy}", 32'(got), 32'(exp));
  endtask

  task automatic tick();
    logic a;
    step(a);
  endtask

  task automatic goto_pos(input int t);
    for (int k = 0; k < FRAME && mp != t; k++) tick();
  endtask

  task automatic offer(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
    logic acc;
    logic got_it;
    got_it       = 1'b0;
    value_in     = v;
    digit_en_in  = en;
    dp_in        = dp;
    update_valid = 1'b1;
    for (int k = 0; k < 200 && !got_it; k++) begin
      step(acc);
      got_it = acc;
    end
    update_valid = 1'b0;
    check("accept", 32'(got_it), 32'd1);
  endtask

  int fs_cnt;
  int lit_cnt;

  initial begin
    mp = 0; m_full = 1'b0; m_pend = '0; m_act = '0;

    // Reset and idle scanning
    ARESET = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
    fs_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (frame_start) fs_cnt++;
    end
    check("idle_frame_pulses", 32'(fs_cnt), 32'd2);

    // Basic display, update mid-frame
    goto_pos(20);
    offer(32'h0123_4567, 8'hFF, 8'h00);
    check("rdy_after_accept", 32'(update_ready), 32'd0);
    goto_pos(0);
    goto_pos(2);  tick();
    check("d0_anode", 32'(anode), 32'hFE);
    check("d0_seg", 32'(segment), 32'hF8);
    goto_pos(10); tick();
    check("d1_anode", 32'(anode), 32'hFD);
    check("d1_seg", 32'(segment), 32'h82);
    goto_pos(58); tick();
    check("d7_anode", 32'(anode), 32'h7F);
    check("d7_seg", 32'(segment), 32'hC0);

    // Backpressure: second update waits for the boundary
    offer(32'h89AB_CDEF, 8'hFF, 8'h00);
    value_in = 32'h7654_3210; digit_en_in = 8'hFF; dp_in = 8'hFF;
    update_valid = 1'b1;
    tick();
    check("rdy_while_full", 32'(update_ready), 32'd0);
    offer(32'h7654_3210, 8'hFF, 8'hFF);
    check("bp_accept_pos", 32'(mp), 32'd1);
    goto_pos(2);  tick();
    check("first_d0_seg", 32'(segment), 32'h8E);
    goto_pos(0);
    goto_pos(2);  tick();
    check("second_d0_seg", 32'(segment), 32'h40);
    goto_pos(58); tick();
    check("second_d7_seg", 32'(segment), 32'h78);

    // Digit-enable and decimal-point masks
    offer(32'hFFFF_FFFF, 8'h0F, 8'h01);
    goto_pos(0);
    goto_pos(2);  tick();
    check("mask_d0_seg", 32'(segment), 32'h0E);
    goto_pos(10); tick();
    check("mask_d1_seg", 32'(segment), 32'h8E);
    goto_pos(34); tick();
    check("mask_d4_anode", 32'(anode), 32'hFF);
    check("mask_d4_seg", 32'(segment), 32'hFF);
    goto_pos(26); tick();
    check("mask_d3_anode", 32'(anode), 32'hF7);

    // Reset mid-frame with an update pending
    offer(32'h1234_5678, 8'hFF, 8'h00);
    goto_pos(35);
    ARESET = 1'b1;
    tick();
    check("rst_anode", 32'(anode), 32'hFF);
    check("rst_seg", 32'(segment), 32'hFF);
    check("rst_ready", 32'(update_ready), 32'd1);
    ARESET = 1'b0;
    lit_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (anode != 8'hFF) lit_cnt++;
    end
    check("post_reset_dark", 32'(lit_cnt), 32'd0);

    // Update offered exactly in the frame-boundary cycle
    goto_pos(FRAME - 1);
    offer(32'h0000_00A5, 8'h01, 8'h00);
    check("race_rdy", 32'(update_ready), 32'd0);
    goto_pos(2);  tick();
    check("race_not_bypassed", 32'(segment), 32'hFF);
    goto_pos(0);
    goto_pos(2);  tick();
    check("race_d0_anode", 32'(anode), 32'hFE);
    check("race_d0_seg", 32'(segment), 32'h92);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
